// File: rtl/lcd_object_writer.sv
// Character-LCD sprite renderer: runs the HD44780 power-on init, then on each
// request erases the sprite's previous cells with spaces and draws it at the new position.
module lcd_object_writer #(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int OBJ_W      = 3,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 4,
  parameter int CLR_WAIT   = 100,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [7:0]    glyph_base,
  output logic          ready,
  output logic          done,
  output logic [7:0]    lcd_data,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en
);

  localparam int MAX_A   = (CLR_WAIT > GAP_CYCLES) ? CLR_WAIT : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_A > EN_CYCLES) ? MAX_A : EN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT - 1);
  localparam logic [6:0]       COLS_7   = 7'(COLS);
  localparam logic [3:0]       OBJ_4    = 4'(OBJ_W);
  localparam logic [RW:0]      ROWS_V   = (RW + 1)'(ROWS);
  localparam logic [CW:0]      COLS_V   = (CW + 1)'(COLS);

  typedef enum logic [3:0] {
    S_INIT_CLR,
    S_INIT_ENTRY,
    S_INIT_DISP,
    S_IDLE,
    S_ERASE_ADDR,
    S_ERASE_DATA,
    S_DRAW_ADDR,
    S_DRAW_DATA,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_t;

  state_t           r_state;
  state_t           w_stateN;
  phase_t           r_phase;
  phase_t           w_phaseN;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntN;
  logic [3:0]       r_cell;
  logic [3:0]       w_cellN;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [7:0]       r_glyph;
  logic             r_oor;
  logic [RW-1:0]    r_prevRow;
  logic [CW-1:0]    r_prevCol;
  logic             r_prevValid;

  logic             w_rowOk;
  logic             w_colOk;
  logic             w_inRange;
  logic             w_accept;
  logic             w_needErase;
  logic             w_txnState;
  logic             w_txnEnd;
  logic [CNT_W-1:0] w_holdLast;
  logic [3:0]       w_eraseN;
  logic [3:0]       w_drawN;
  logic [3:0]       w_cellInc;
  logic [7:0]       w_busData;
  logic             w_busRs;

  function automatic logic [6:0] ddramAddr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [6:0] base;
    case (2'(r))
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'h14;
      default: base = 7'h54;
    endcase
    return base + 7'(c);
  endfunction

  // Cells that fit between a column and the right edge, capped at the sprite width.
  function automatic logic [3:0] cellCount(input logic [CW-1:0] c);
    logic [6:0] rem;
    rem = COLS_7 - 7'(c);
    return (rem < 7'(OBJ_W)) ? rem[3:0] : OBJ_4;
  endfunction

  if (ROWS == (1 << RW)) begin : g_rowFull
    assign w_rowOk = 1'b1;
  end else begin : g_rowPart
    assign w_rowOk = ({1'b0, row} < ROWS_V);
  end

  if (COLS == (1 << CW)) begin : g_colFull
    assign w_colOk = 1'b1;
  end else begin : g_colPart
    assign w_colOk = ({1'b0, col} < COLS_V);
  end

  assign w_inRange   = w_rowOk && w_colOk;
  assign w_accept    = (r_state == S_IDLE) && req;
  assign w_needErase = r_prevValid && !((r_prevRow == row) && (r_prevCol == col));
  assign w_txnState  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_holdLast  = (r_state == S_INIT_CLR) ? CLR_LAST : GAP_LAST;
  assign w_txnEnd    = w_txnState && (r_phase == PH_HOLD) && (r_cnt == w_holdLast);
  assign w_eraseN    = cellCount(r_prevCol);
  assign w_drawN     = cellCount(r_col);
  assign w_cellInc   = r_cell + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT_CLR;
      r_phase     <= PH_SETUP;
      r_cnt       <= '0;
      r_cell      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_glyph     <= '0;
      r_oor       <= 1'b0;
      r_prevRow   <= '0;
      r_prevCol   <= '0;
      r_prevValid <= 1'b0;
    end else begin
      r_state <= w_stateN;
      r_phase <= w_phaseN;
      r_cnt   <= w_cntN;
      r_cell  <= w_cellN;
      if (w_accept) begin
        r_row   <= row;
        r_col   <= col;
        r_glyph <= glyph_base;
        r_oor   <= !w_inRange;
      end
      if ((r_state == S_DONE) && !r_oor) begin
        r_prevRow   <= r_row;
        r_prevCol   <= r_col;
        r_prevValid <= 1'b1;
      end
    end
  end

  // Every bus-driving state runs one SETUP/STROBE/HOLD transaction.
  always_comb begin
    w_phaseN = r_phase;
    w_cntN   = r_cnt;
    if (w_txnState) begin
      case (r_phase)
        PH_SETUP: begin
          w_phaseN = PH_STROBE;
          w_cntN   = '0;
        end
        PH_STROBE: begin
          if (r_cnt == EN_LAST) begin
            w_phaseN = PH_HOLD;
            w_cntN   = '0;
          end else begin
            w_cntN = r_cnt + CNT_W'(1);
          end
        end
        PH_HOLD: begin
          if (r_cnt == w_holdLast) begin
            w_phaseN = PH_SETUP;
            w_cntN   = '0;
          end else begin
            w_cntN = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_phaseN = PH_SETUP;
          w_cntN   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_stateN  = r_state;
    w_cellN   = r_cell;
    w_busData = 8'h00;
    w_busRs   = 1'b0;
    case (r_state)
      S_INIT_CLR: begin
        w_busData = 8'h01;
        if (w_txnEnd) w_stateN = S_INIT_ENTRY;
      end
      S_INIT_ENTRY: begin
        w_busData = 8'h06;
        if (w_txnEnd) w_stateN = S_INIT_DISP;
      end
      S_INIT_DISP: begin
        w_busData = 8'h0C;
        if (w_txnEnd) w_stateN = S_IDLE;
      end
      S_IDLE: begin
        if (req) begin
          w_cellN = '0;
          if (!w_inRange) begin
            w_stateN = S_DONE;
          end else if (w_needErase) begin
            w_stateN = S_ERASE_ADDR;
          end else begin
            w_stateN = S_DRAW_ADDR;
          end
        end
      end
      S_ERASE_ADDR: begin
        w_busData = {1'b1, ddramAddr(r_prevRow, r_prevCol)};
        if (w_txnEnd) begin
          w_stateN = S_ERASE_DATA;
          w_cellN  = '0;
        end
      end
      S_ERASE_DATA: begin
        w_busData = 8'h20;
        w_busRs   = 1'b1;
        if (w_txnEnd) begin
          if (w_cellInc == w_eraseN) begin
            w_stateN = S_DRAW_ADDR;
            w_cellN  = '0;
          end else begin
            w_cellN = w_cellInc;
          end
        end
      end
      S_DRAW_ADDR: begin
        w_busData = {1'b1, ddramAddr(r_row, r_col)};
        if (w_txnEnd) begin
          w_stateN = S_DRAW_DATA;
          w_cellN  = '0;
        end
      end
      S_DRAW_DATA: begin
        w_busData = r_glyph + {4'b0000, r_cell};
        w_busRs   = 1'b1;
        if (w_txnEnd) begin
          if (w_cellInc == w_drawN) begin
            w_stateN = S_DONE;
          end else begin
            w_cellN = w_cellInc;
          end
        end
      end
      S_DONE: begin
        w_stateN = S_IDLE;
      end
      default: begin
        w_stateN = S_INIT_CLR;
      end
    endcase
  end

  // Bus outputs are gated by rst so the strobe and data clear the instant reset asserts.
  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
  assign lcd_rw   = 1'b0;
  assign lcd_en   = rst && (r_phase == PH_STROBE);
  assign lcd_data = rst ? w_busData : 8'h00;
  assign lcd_rs   = rst && w_busRs;

endmodule
